// File: rtl/vga_pkg.sv
// Shared VGA/VRAM definitions: the pixel colour type, the frame size,
// the byte-strobe patterns for half-word and full-word VRAM writes,
// and the rectangle-fill FSM states.
package vga_pkg;

  typedef logic [11:0] rgb444_t;

  localparam int VRAM_W = 256;
  localparam int VRAM_H = 256;

  localparam logic [3:0] STRB_LO  = 4'b0011;
  localparam logic [3:0] STRB_HI  = 4'b1100;
  localparam logic [3:0] STRB_ALL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } fill_state_e;

endpackage

// File: rtl/vram_rect_fill.sv
// Rectangle-fill engine: turns one start command into a stream of 32-bit
// VRAM word writes carrying a solid RGB444 colour. Horizontally adjacent
// even/odd pixel pairs are merged into one full-word write.
// Optional build macro VRAM_RECT_FILL_CLIP_EN: clip the rectangle at the
// right and bottom screen edges instead of wrapping around.
module vram_rect_fill
  import vga_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              mem_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        x0,
  input  logic [7:0]        y0,
  input  logic [8:0]        w,
  input  logic [8:0]        h,
  input  logic [11:0]       color,
  output logic              busy,
  output logic              done,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb
);

  fill_state_e state_q, state_d;
  logic [7:0]  x0_q, x0_d;
  logic [8:0]  width_q, width_d;
  rgb444_t     color_q, color_d;
  logic [7:0]  cx_q, cx_d;
  logic [7:0]  cy_q, cy_d;
  logic [8:0]  rem_q, rem_d;
  logic [8:0]  rows_q, rows_d;

  logic        pairBeat;
  logic [8:0]  step;
  logic [8:0]  remAfter;
  logic [3:0]  beatStrb;
  logic [8:0]  effW;
  logic [8:0]  effH;
  logic        accepting;

  // Work out the size actually drawn: clipped to the screen edge when
  // clipping is built in, otherwise the raw size (cursor wraps instead).
  always_comb begin
`ifdef VRAM_RECT_FILL_CLIP_EN
    effW = w;
    effH = h;
    if (w > (9'(VRAM_W) - {1'b0, x0})) effW = 9'(VRAM_W) - {1'b0, x0};
    if (h > (9'(VRAM_H) - {1'b0, y0})) effH = 9'(VRAM_H) - {1'b0, y0};
`else
    effW = w;
    effH = h;
`endif
  end

  // Form the current beat from the cursor: an even cursor with two or more
  // pixels left writes a whole word, anything else writes one half-word.
  always_comb begin
    pairBeat = !cx_q[0] && (rem_q >= 9'd2);
    step     = pairBeat ? 9'd2 : 9'd1;
    remAfter = rem_q - step;
    if (pairBeat)      beatStrb = STRB_ALL;
    else if (cx_q[0])  beatStrb = STRB_HI;
    else               beatStrb = STRB_LO;
  end

  assign accepting = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Next-state logic: command latch, cursor advance on each accepted beat,
  // and row/rectangle end detection.
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    width_d = width_q;
    color_d = color_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    rem_d   = rem_q;
    rows_d  = rows_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accepting) begin
          x0_d    = x0;
          width_d = effW;
          color_d = color;
          cx_d    = x0;
          cy_d    = y0;
          rem_d   = effW;
          rows_d  = effH;
          state_d = ((w == 9'd0) || (h == 9'd0)) ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (wr_ready) begin
          if (remAfter == 9'd0) begin
            if (rows_q == 9'd1) begin
              state_d = ST_DONE;
            end else begin
              cx_d   = x0_q;
              rem_d  = width_q;
              cy_d   = cy_q + 8'd1;
              rows_d = rows_q - 9'd1;
            end
          end else begin
            cx_d  = cx_q + step[7:0];
            rem_d = remAfter;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and cursor registers; reset aborts any fill in progress.
  always_ff @(posedge mem_clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      x0_q    <= '0;
      width_q <= '0;
      color_q <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      rem_q   <= '0;
      rows_q  <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      width_q <= width_d;
      color_q <= color_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      rem_q   <= rem_d;
      rows_q  <= rows_d;
    end
  end

  // Outputs decode straight from the state so they drop the moment reset
  // asserts; the write port reads all-zero whenever no beat is presented.
  always_comb begin
    busy     = (state_q == ST_WRITE);
    done     = (state_q == ST_DONE);
    wr_valid = busy;
    wr_addr  = '0;
    wr_data  = '0;
    wr_strb  = '0;
    if (wr_valid) begin
      wr_addr = ADDR_W'({cy_q, cx_q[7:1], 2'b00});
      wr_data = {4'h0, color_q, 4'h0, color_q};
      wr_strb = beatStrb;
    end
  end

endmodule

// File: tb/tb_vram_rect_fill.sv
// Scoreboard bench for vram_rect_fill: each fill pushes its hand-computed
// beats into a queue; an independent monitor drives wr_ready (with an
// optional stall window) and checks every presented beat against the queue.
module tb_vram_rect_fill;

  typedef struct packed {
    logic [16:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } beat_t;

  logic        mem_clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  x0, y0;
  logic [8:0]  w, h;
  logic [11:0] color;
  logic        busy, done, wr_valid, wr_ready;
  logic [16:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  beat_t expQ[$];
  int compared = 0;
  int mismatched = 0;
  int beatIdx = 0;
  int stallAt = -1;
  int stallLen = 0;

  vram_rect_fill #(.ADDR_W(17)) dut (
    .mem_clk  (mem_clk),
    .rst      (rst),
    .start    (start),
    .x0       (x0),
    .y0       (y0),
    .w        (w),
    .h        (h),
    .color    (color),
    .busy     (busy),
    .done     (done),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_strb  (wr_strb)
  );

  // 100 MHz clock
  always #5 mem_clk = ~mem_clk;

  // Single comparison point: counts every check and reports failures.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushBeat(input logic [16:0] addr, input logic [11:0] col, input logic [3:0] strb);
    beat_t b;
    b.addr = addr;
    b.data = {4'h0, col, 4'h0, col};
    b.strb = strb;
    expQ.push_back(b);
  endtask

  // Issue one command at the current falling edge; start is sampled at the
  // next rising edge and released just after it.
  task automatic applyStimulus(input logic [7:0] ax, input logic [7:0] ay,
                               input logic [8:0] aw, input logic [8:0] ah,
                               input logic [11:0] acol);
    beatIdx = 0;
    x0 = ax; y0 = ay; w = aw; h = ah; color = acol;
    start = 1'b1;
    @(posedge mem_clk);
    #1;
    start = 1'b0;
    x0 = ~ax; y0 = ~ay; w = 9'h1FF; h = 9'h1FF; color = ~acol;
  endtask

  // Run a full command and check busy, done latency (rising edges after the
  // start edge) and that every expected beat was consumed.
  task automatic runFill(input string tag, input logic [7:0] ax, input logic [7:0] ay,
                         input logic [8:0] aw, input logic [8:0] ah,
                         input logic [11:0] acol, input int expEdges, input bit expBusy);
    int edges;
    applyStimulus(ax, ay, aw, ah, acol);
    edges = 0;
    @(negedge mem_clk);
    checkOutput({tag, "_busy"}, busy, expBusy);
    while (!done && edges < 2000) begin
      @(negedge mem_clk);
      edges++;
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_done_timeout: got no done, expected done after %0d edges", tag, expEdges);
    end else begin
      checkOutput({tag, "_done_latency"}, edges, expEdges);
      checkOutput({tag, "_valid_at_done"}, wr_valid, 0);
      checkOutput({tag, "_busy_at_done"}, busy, 0);
    end
    checkOutput({tag, "_beats_left"}, expQ.size(), 0);
  endtask

  // Monitor: decides wr_ready for the coming edge, then checks the beat on
  // the port against the scoreboard head; pops only when it will be taken.
  initial begin
    beat_t e;
    wr_ready = 1'b1;
    forever begin
      @(negedge mem_clk);
      if (wr_valid && stallLen > 0 && beatIdx == stallAt) begin
        wr_ready = 1'b0;
        stallLen--;
      end else begin
        wr_ready = 1'b1;
      end
      if (wr_valid) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_beat: got beat at addr 0x%0h, expected none", wr_addr);
        end else begin
          e = expQ[0];
          checkOutput("beat_addr", wr_addr, e.addr);
          checkOutput("beat_data", wr_data, e.data);
          checkOutput("beat_strb", wr_strb, e.strb);
          if (wr_ready) begin
            void'(expQ.pop_front());
            beatIdx++;
          end
        end
      end
    end
  end

  // Global safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rst = 1'b0;
    start = 1'b0;
    x0 = '0; y0 = '0; w = '0; h = '0; color = '0;
    repeat (3) @(posedge mem_clk);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_valid", wr_valid, 0);
    checkOutput("reset_addr", wr_addr, 0);
    checkOutput("reset_strb", wr_strb, 0);
    checkOutput("reset_data", wr_data, 0);
    rst = 1'b1;
    @(negedge mem_clk);

    // aligned 4x1
    pushBeat(17'h00000, 12'hABC, 4'b1111);
    pushBeat(17'h00004, 12'hABC, 4'b1111);
    runFill("aligned", 8'd0, 8'd0, 9'd4, 9'd1, 12'hABC, 2, 1'b1);

    // unaligned 3x1 at (1,2)
    pushBeat(17'h00400, 12'h123, 4'b1100);
    pushBeat(17'h00404, 12'h123, 4'b1111);
    runFill("unaligned", 8'd1, 8'd2, 9'd3, 9'd1, 12'h123, 2, 1'b1);

    // odd start, odd-ending rows: half, full, half per row
    pushBeat(17'h00004, 12'h00F, 4'b1100);
    pushBeat(17'h00008, 12'h00F, 4'b1111);
    pushBeat(17'h0000C, 12'h00F, 4'b0011);
    pushBeat(17'h00204, 12'h00F, 4'b1100);
    pushBeat(17'h00208, 12'h00F, 4'b1111);
    pushBeat(17'h0020C, 12'h00F, 4'b0011);
    runFill("oddrows", 8'd3, 8'd0, 9'd4, 9'd2, 12'h00F, 6, 1'b1);

    // 4x2 with the second beat stalled for three cycles
    stallAt = 1;
    stallLen = 3;
    pushBeat(17'h00614, 12'hF00, 4'b1111);
    pushBeat(17'h00618, 12'hF00, 4'b1111);
    pushBeat(17'h00814, 12'hF00, 4'b1111);
    pushBeat(17'h00818, 12'hF00, 4'b1111);
    runFill("backpressure", 8'd10, 8'd3, 9'd4, 9'd2, 12'hF00, 7, 1'b1);
    stallAt = -1;
    stallLen = 0;

    // zero size, then a new command on the done cycle
    runFill("zero", 8'd7, 8'd7, 9'd0, 9'd5, 12'h333, 0, 1'b0);
    pushBeat(17'h00008, 12'h0F0, 4'b1100);
    runFill("after_zero", 8'd5, 8'd0, 9'd1, 9'd1, 12'h0F0, 1, 1'b1);

    // bottom-right corner
`ifdef VRAM_RECT_FILL_CLIP_EN
    pushBeat(17'h1FFFC, 12'h777, 4'b1111);
    runFill("corner", 8'd254, 8'd255, 9'd4, 9'd2, 12'h777, 1, 1'b1);
`else
    pushBeat(17'h1FFFC, 12'h777, 4'b1111);
    pushBeat(17'h1FE00, 12'h777, 4'b1111);
    pushBeat(17'h001FC, 12'h777, 4'b1111);
    pushBeat(17'h00000, 12'h777, 4'b1111);
    runFill("corner", 8'd254, 8'd255, 9'd4, 9'd2, 12'h777, 4, 1'b1);
`endif

    // reset in the middle of a 16x4 fill
    for (int i = 0; i < 8; i++) pushBeat(17'(i * 4), 12'hC3C, 4'b1111);
    applyStimulus(8'd0, 8'd0, 9'd16, 9'd4, 12'hC3C);
    repeat (4) @(posedge mem_clk);
    #1;
    checkOutput("prereset_busy", busy, 1);
    rst = 1'b0;
    #1;
    checkOutput("midreset_valid", wr_valid, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_done", done, 0);
    expQ.delete();
    repeat (3) @(posedge mem_clk);
    #1;
    rst = 1'b1;
    @(negedge mem_clk);
    pushBeat(17'h00204, 12'h5A5, 4'b1111);
    runFill("post_reset", 8'd2, 8'd1, 9'd2, 9'd1, 12'h5A5, 1, 1'b1);

    repeat (2) @(negedge mem_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
